multu_sequencer: RTL

- Multi-cycle unsigned multiply unit with its HI/LO register pair. It sequences MULTU for the single-cycle core.
- The decoder raises start for MULTU, rdhilo for MFHI/MFLO and wrhi/wrlo for MTHI/MTLO.
- The block runs a radix-2 shift-add loop over WIDTH cycles. It asserts stall to freeze the PC/pipeline when an instruction needs HI/LO or the multiplier while a multiply is in flight.

---
 rtl/multu_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/multu_sequencer.sv
// Multi-cycle unsigned multiplier with architectural HI/LO registers.
// Radix-2 shift-add over WIDTH cycles; stalls the core while a multiply is in flight.
//
// state | meaning
// IDLE  | no multiply in flight; MTHI/MTLO writes and new starts accepted
// RUN   | shift-add iteration, one multiplier bit per cycle
module multu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             rdhilo,
    input  logic             wrhi,
    input  logic             wrlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] mcand, mcand_nxt;
    logic [WIDTH-1:0] mplier, mplier_nxt;
    logic [WIDTH:0]   acc, acc_nxt;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic             done_nxt;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] shifted;

    // acc stays below 2^WIDTH after every shift, so WIDTH+1 bits hold the sum
    always_comb begin
        addend  = mplier[0] ? mcand : '0;
        sum     = acc + {1'b0, addend};
        shifted = {sum, mplier} >> 1;
    end

    assign busy  = (state == RUN);
    assign stall = busy & (start | rdhilo | wrhi | wrlo);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        hi_nxt     = hi;
        lo_nxt     = lo;
        done_nxt   = 1'b0;

        case (state)
            IDLE: begin
                // start takes priority; a concurrent MTHI/MTLO is dropped
                if (start) begin
                    mcand_nxt  = srca;
                    mplier_nxt = srcb;
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
                    state_nxt  = RUN;
                end else begin
                    if (wrhi) hi_nxt = wdata;
                    if (wrlo) lo_nxt = wdata;
                end
            end
            RUN: begin
                acc_nxt    = shifted[2*WIDTH:WIDTH];
                mplier_nxt = shifted[WIDTH-1:0];
                cnt_nxt    = cnt + CW'(1);
                if (cnt == LAST) begin
                    hi_nxt    = shifted[2*WIDTH-1:WIDTH];
                    lo_nxt    = shifted[WIDTH-1:0];
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            acc    <= acc_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
            done   <= done_nxt;
        end
    end

endmodule
